// File: rtl/sysid_check_pkg.sv
// Shared definitions for the sysid check sequencer: FSM state encoding,
// Avalon word addresses of the sysid slave, and the timer width helper.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_CHECK,
    S_FLUSH,
    S_FIN
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Width needed for a counter that must reach the value n.
  function automatic int tmr_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sysid_check_timer.sv
// Clearable up-counter with terminal-count output.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   clr            : first cycle of a new phase; count treated as 0 this cycle
//   en             : advance the count
//   term           : terminal value (phase length minus one)
//   tc             : current count equals term
module sysid_check_timer #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;
  logic [W-1:0] cur;

  // Clear acts on the current cycle's value so the first cycle of a phase
  // already counts as cycle 0 and a one-cycle phase is possible.
  assign cur = clr ? '0 : cnt;
  assign tc  = (cur == term);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (en)   cnt <= cur + 1'b1;
  end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads the sysid ID (addr 0) and timestamp (addr 1) over Avalon-MM and
// compares them to build-time values. Runs after reset (AUTO_START) and on
// each start pulse while idle; a read timeout flushes and retries the whole
// sequence up to MAX_RETRY times.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   start                 : one-cycle run request (ignored while busy)
//   avm_*                 : Avalon-MM read master (pipelined, waitrequest)
//   busy, done            : sequence in progress / one-cycle end pulse
//   pass, *_mismatch,
//   timeout               : result flags, valid when done is high
//   id_value, ts_value    : last captured words
//   retry_count           : retries used by current/last sequence
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS  = 32'h59252B95,
  parameter int          TIMEOUT      = 256,
  parameter int          MAX_RETRY    = 3,
  parameter int          FLUSH_CYCLES = 16,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  retry_count
);

  localparam int TW = tmr_w((TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES);

  state_t        state;
  logic          first;      // first cycle of an RD_x or FLUSH phase
  logic          auto_pend;  // post-reset run not yet launched
  logic          tmr_en;
  logic          tmr_tc;
  logic [TW-1:0] tmr_term;

  // One timer serves both the per-read timeout (RD_x + WAIT_x) and FLUSH.
  assign tmr_en   = (state == S_RD_ID) || (state == S_WAIT_ID) ||
                    (state == S_RD_TS) || (state == S_WAIT_TS) ||
                    (state == S_FLUSH);
  assign tmr_term = (state == S_FLUSH) ? TW'(FLUSH_CYCLES - 1) : TW'(TIMEOUT - 1);

  sysid_check_timer #(.W(TW)) u_tmr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (first),
    .en      (tmr_en),
    .term    (tmr_term),
    .tc      (tmr_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      first       <= 1'b0;
      auto_pend   <= AUTO_START;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_count <= '0;
    end else begin
      done  <= 1'b0;
      first <= 1'b0;
      case (state)
        S_IDLE: if (start || auto_pend) begin
          auto_pend   <= 1'b0;
          pass        <= 1'b0;
          id_mismatch <= 1'b0;
          ts_mismatch <= 1'b0;
          timeout     <= 1'b0;
          retry_count <= '0;
          busy        <= 1'b1;
          avm_read    <= 1'b1;
          avm_address <= ADDR_ID;
          first       <= 1'b1;
          state       <= S_RD_ID;
        end
        S_RD_ID, S_RD_TS, S_WAIT_ID, S_WAIT_TS: begin
          // A response arriving on the last allowed cycle still counts;
          // in RD_x the timeout wins over a late acceptance.
          if ((state == S_WAIT_ID) && avm_readdatavalid) begin
            id_value    <= avm_readdata;
            avm_read    <= 1'b1;
            avm_address <= ADDR_TS;
            first       <= 1'b1;
            state       <= S_RD_TS;
          end else if ((state == S_WAIT_TS) && avm_readdatavalid) begin
            ts_value <= avm_readdata;
            state    <= S_CHECK;
          end else if (tmr_tc) begin
            avm_read <= 1'b0;
            if (retry_count < 3'(MAX_RETRY)) begin
              retry_count <= retry_count + 3'd1;
              first       <= 1'b1;
              state       <= S_FLUSH;
            end else begin
              timeout <= 1'b1;
              done    <= 1'b1;
              state   <= S_FIN;
            end
          end else if ((state == S_RD_ID) && !avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_WAIT_ID;
          end else if ((state == S_RD_TS) && !avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_WAIT_TS;
          end
        end
        S_CHECK: begin
          id_mismatch <= (id_value != EXPECTED_ID);
          ts_mismatch <= (ts_value != EXPECTED_TS);
          pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
          done        <= 1'b1;
          state       <= S_FIN;
        end
        // Stragglers from the timed-out read are dropped here, not in WAIT_x.
        S_FLUSH: if (tmr_tc) begin
          avm_read    <= 1'b1;
          avm_address <= ADDR_ID;
          first       <= 1'b1;
          state       <= S_RD_ID;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
module tb_sysid_check_ctrl;

  localparam logic [31:0] EID = 32'hACD51302;
  localparam logic [31:0] ETS = 32'h59252B95;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;
  logic [2:0]  retry_count;

  int n_vec = 0;
  int n_err = 0;

  // slave configuration (written by the stimulus only)
  int          ws = 0;
  logic [31:0] id_data = EID;
  logic [31:0] ts_data = ETS;
  int          drop_lo = 0;
  int          drop_hi = 0;
  int          late_dly = 0;

  // slave state (written by the slave only)
  int   acc_count = 0;
  int   rd_ids = 0;
  int   stalls = 0;
  int   viol = 0;
  int   stall_cnt = 0;
  int   late_cnt = 0;
  logic acc = 1'b0;
  logic acc_drop = 1'b0;
  logic acc_addr = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_addr = 1'b0;

  always #5 clock = ~clock;

  sysid_check_ctrl #(
    .EXPECTED_ID (EID),
    .EXPECTED_TS (ETS),
    .TIMEOUT     (8),
    .MAX_RETRY   (3),
    .FLUSH_CYCLES(16),
    .AUTO_START  (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value),
    .retry_count       (retry_count)
  );

  // Avalon slave: ws stall cycles per read, one-cycle latency, optional
  // dropped responses (index window) with an optional late 0xDEADBEEF.
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    if (!reset_n) begin
      acc = 1'b0; stall_cnt = 0; late_cnt = 0;
      avm_waitrequest = 1'b0; prev_stall = 1'b0;
    end else begin
      if (late_cnt > 0) begin
        late_cnt--;
        if (late_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = 32'hDEADBEEF;
        end
      end
      if (acc) begin
        acc = 1'b0;
        if (acc_drop) begin
          if (late_dly > 0) late_cnt = late_dly - 1;
        end else begin
          avm_readdatavalid = 1'b1;
          avm_readdata = acc_addr ? ts_data : id_data;
        end
      end
      if (prev_stall && (!avm_read || avm_address != prev_addr)) viol++;
      if (avm_read) begin
        if (stall_cnt < ws) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
          stalls++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          acc = 1'b1;
          acc_addr = avm_address;
          acc_drop = (acc_count >= drop_lo) && (acc_count < drop_hi);
          acc_count++;
          if (avm_address == 1'b0) rd_ids++;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Called at a negedge (cycle 0). Optional start pulse at cycle 0 and an
  // extra one at cycle extra_at; returns the cycle in which done was seen.
  task automatic run(input logic use_start, input int extra_at, output int cyc);
    start = use_start;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      start = (cyc == extra_at);
    end while (!done && cyc < 400);
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_flags(input string tag, input logic p, input logic im,
                           input logic tm, input logic to, input logic [2:0] rc);
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_idmm"}, 32'(id_mismatch), 32'(im));
    chk({tag, "_tsmm"}, 32'(ts_mismatch), 32'(tm));
    chk({tag, "_tmo"}, 32'(timeout), 32'(to));
    chk({tag, "_retry"}, 32'(retry_count), 32'(rc));
  endtask

  initial begin
    int cyc, base, busy_seen;
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);

    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idv", id_value, 0);
    chk("rst_tsv", ts_value, 0);
    chk_flags("rst", 0, 0, 0, 0, 0);

    // 1: auto start after reset, matching slave, zero wait
    reset_n = 1'b1;
    run(1'b0, -1, cyc);
    chk("t1_cyc", cyc, 6);
    chk("t1_busy6", 32'(busy), 1);
    chk_flags("t1", 1, 0, 0, 0, 0);
    chk("t1_idv", id_value, EID);
    chk("t1_tsv", ts_value, ETS);
    @(negedge clock);
    chk("t1_busy7", 32'(busy), 0);
    chk("t1_done7", 32'(done), 0);

    // 2: ID reads as zero
    id_data = 32'h0;
    run(1'b1, -1, cyc);
    chk("t2_cyc", cyc, 6);
    chk_flags("t2", 0, 1, 0, 0, 0);
    chk("t2_idv", id_value, 0);
    @(negedge clock);

    // 3: five waitrequest cycles per read
    id_data = EID; ws = 5; base = stalls;
    run(1'b1, -1, cyc);
    chk("t3_cyc", cyc, 16);
    chk_flags("t3", 1, 0, 0, 0, 0);
    chk("t3_stalls", stalls - base, 10);
    chk("t3_stable", viol, 0);
    @(negedge clock);

    // 4: slave never responds -> 3 flushes then timeout
    ws = 0; drop_lo = acc_count; drop_hi = acc_count + 100; base = rd_ids;
    run(1'b1, -1, cyc);
    chk("t4_cyc", cyc, 81);
    chk_flags("t4", 0, 0, 0, 1, 3);
    chk("t4_idreads", rd_ids - base, 4);
    @(negedge clock);

    // 5: first ID read lost, late DEADBEEF lands in FLUSH
    drop_lo = acc_count; drop_hi = acc_count + 1; late_dly = 10;
    run(1'b1, -1, cyc);
    chk("t5_cyc", cyc, 30);
    chk_flags("t5", 1, 0, 0, 0, 1);
    chk("t5_idv", id_value, EID);
    @(negedge clock);
    drop_hi = 0; late_dly = 0;

    // 6a: start while busy is neither acted on nor queued
    run(1'b1, 3, cyc);
    chk("t6_cyc", cyc, 6);
    chk_flags("t6", 1, 0, 0, 0, 0);
    busy_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy) busy_seen++;
    end
    chk("t6_noqueue", busy_seen, 0);

    // 6b: reset during WAIT_TS
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_wts_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_idv", id_value, 0);
    chk_flags("t6rst", 0, 0, 0, 0, 0);

    // 6c: reset while a stalled read is on the bus drops avm_read at once
    ws = 5;
    @(negedge clock); reset_n = 1'b1;
    repeat (9) @(negedge clock);
    chk("t6_rd_on", 32'(avm_read), 1);
    chk("t6_rd_addr", 32'(avm_address), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rd_async", 32'(avm_read), 0);
    chk("t6_addr_rst", 32'(avm_address), 0);

    // rerun after release
    ws = 0;
    @(negedge clock); reset_n = 1'b1;
    run(1'b0, -1, cyc);
    chk("t6_rerun_cyc", cyc, 6);
    chk_flags("t6rr", 1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
